// File: rtl/uart_tx_sched_if.sv
// Byte-stream handshake bundle for the two requesters sharing one UART transmitter.
// Requesters drive master; the scheduler consumes slave.
interface uart_tx_sched_if;
   logic       a_valid;
   logic [7:0] a_data;
   logic       a_last;
   logic       a_ready;
   logic       b_valid;
   logic [7:0] b_data;
   logic       b_last;
   logic       b_ready;

   modport master (
      output a_valid, a_data, a_last, b_valid, b_data, b_last,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_valid, a_data, a_last, b_valid, b_data, b_last,
      output a_ready, b_ready
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler feeding one uart_send: one byte per BYTE_CYCLES slot, strobe starts the cycle after transfer.
// Ready is offered only in LOAD to the owner; a stalled owner keeps the packet lock indefinitely.
module uart_tx_sched #(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 115200,
   parameter int GAP_CYCLES = 16,
   parameter int STROBE_LEN = 4
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   uart_tx_sched_if.slave req,
   output logic           uart_en,
   output logic [7:0]     uart_din,
   output logic           busy,
   output logic           owner,
   output logic           pkt_done
);

   localparam int          BPS_CNT     = CLK_FREQ / UART_BPS;
   localparam int          BYTE_CYCLES = 10 * BPS_CNT + GAP_CYCLES;
   localparam logic [15:0] SLOT_END    = 16'(BYTE_CYCLES - 1);
   localparam logic [15:0] SLOT_PRE    = 16'(BYTE_CYCLES - 2);
   localparam logic [15:0] STB_END     = 16'(STROBE_LEN - 1);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_LOAD, S_STROBE, S_WAIT, S_HOLD
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic        owner_nxt;
   logic        ptr, ptr_nxt;
   logic        last_q, last_nxt;
   logic [7:0]  din_nxt;
   logic        done_nxt;

   logic        own_valid;
   logic        own_last;
   logic [7:0]  own_data;

   assign own_valid   = owner ? req.b_valid : req.a_valid;
   assign own_last    = owner ? req.b_last  : req.a_last;
   assign own_data    = owner ? req.b_data  : req.a_data;

   assign req.a_ready = (state == S_LOAD) && !owner;
   assign req.b_ready = (state == S_LOAD) &&  owner;
   assign uart_en     = (state == S_STROBE);
   assign busy        = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      last_nxt  = last_q;
      din_nxt   = uart_din;
      done_nxt  = 1'b0;

      case (state)
         // Lets a frame the transmitter had in flight across reset finish.
         S_INIT: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt == SLOT_END) begin
               cnt_nxt   = 16'd0;
               state_nxt = S_IDLE;
            end
         end

         S_IDLE: begin
            if (req.a_valid && (!req.b_valid || !ptr)) begin
               owner_nxt = 1'b0;
               state_nxt = S_LOAD;
            end else if (req.b_valid) begin
               owner_nxt = 1'b1;
               state_nxt = S_LOAD;
            end
         end

         S_LOAD: begin
            if (own_valid) begin
               din_nxt   = own_data;
               last_nxt  = own_last;
               cnt_nxt   = 16'd0;
               state_nxt = S_STROBE;
            end
         end

         S_STROBE: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt == STB_END) state_nxt = S_WAIT;
         end

         // Non-final bytes decide one cycle early so LOAD fills the slot's last cycle.
         S_WAIT: begin
            cnt_nxt = cnt + 16'd1;
            if (last_q) begin
               if (cnt == SLOT_END) begin
                  done_nxt  = 1'b1;
                  ptr_nxt   = ~owner;
                  state_nxt = S_IDLE;
               end
            end else if (cnt == SLOT_PRE) begin
               state_nxt = own_valid ? S_LOAD : S_HOLD;
            end
         end

         S_HOLD: begin
            if (own_valid) state_nxt = S_LOAD;
         end

         default: state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= S_INIT;
         cnt      <= 16'd0;
         owner    <= 1'b0;
         ptr      <= 1'b0;
         last_q   <= 1'b0;
         uart_din <= 8'd0;
         pkt_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         owner    <= owner_nxt;
         ptr      <= ptr_nxt;
         last_q   <= last_nxt;
         uart_din <= din_nxt;
         pkt_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with BYTE_CYCLES = 104.
module tb_uart_tx_sched;
   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       uart_en;
   logic [7:0] uart_din;
   logic       busy;
   logic       owner;
   logic       pkt_done;

   uart_tx_sched_if ifc();

   uart_tx_sched #(
      .CLK_FREQ(1000), .UART_BPS(100), .GAP_CYCLES(4), .STROBE_LEN(4)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .req      (ifc),
      .uart_en  (uart_en),
      .uart_din (uart_din),
      .busy     (busy),
      .owner    (owner),
      .pkt_done (pkt_done)
   );

   always #5 sys_clk = ~sys_clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [8:0] a_q[$];
   logic [8:0] b_q[$];
   logic       a_en, b_en;
   int         log_cyc[$];
   logic [7:0] log_dat[$];
   logic       log_own[$];
   int         rises, pulses, low_run, min_gap, hi_run, hi_min, hi_max, both_rdy;
   logic       en_prev, seen_fall;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lg_cyc(input int i);
      return (i < log_cyc.size()) ? 32'(log_cyc[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] lg_dat(input int i);
      return (i < log_dat.size()) ? 32'(log_dat[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] lg_own(input int i);
      return (i < log_own.size()) ? 32'(log_own[i]) : 32'hFFFF_FFFF;
   endfunction

   task automatic drive();
      ifc.a_valid = a_en && (a_q.size() > 0);
      ifc.a_data  = (a_q.size() > 0) ? a_q[0][7:0] : 8'h00;
      ifc.a_last  = (a_q.size() > 0) ? a_q[0][8]   : 1'b0;
      ifc.b_valid = b_en && (b_q.size() > 0);
      ifc.b_data  = (b_q.size() > 0) ? b_q[0][7:0] : 8'h00;
      ifc.b_last  = (b_q.size() > 0) ? b_q[0][8]   : 1'b0;
   endtask

   task automatic clear_stats();
      log_cyc.delete(); log_dat.delete(); log_own.delete();
      rises = 0; pulses = 0; low_run = 0; min_gap = 99999;
      hi_run = 0; hi_min = 99999; hi_max = 0; both_rdy = 0;
      en_prev = 1'b0; seen_fall = 1'b0;
   endtask

   // One clock: handshakes sampled mid-cycle, bookkeeping just after the edge.
   task automatic tick();
      logic ta, tb, own_s;
      @(negedge sys_clk);
      ta    = ifc.a_valid && ifc.a_ready && !sys_rst;
      tb    = ifc.b_valid && ifc.b_ready && !sys_rst;
      own_s = owner;
      if (ifc.a_ready && ifc.b_ready) both_rdy++;
      @(posedge sys_clk);
      #1;
      cyc++;
      if (ta) begin
         log_cyc.push_back(cyc); log_dat.push_back(a_q[0][7:0]); log_own.push_back(own_s);
         void'(a_q.pop_front());
      end
      if (tb) begin
         log_cyc.push_back(cyc); log_dat.push_back(b_q[0][7:0]); log_own.push_back(own_s);
         void'(b_q.pop_front());
      end
      if (uart_en && !en_prev) begin
         rises++;
         if (seen_fall && low_run < min_gap) min_gap = low_run;
         low_run = 0;
         hi_run  = 0;
      end
      if (!uart_en && en_prev) begin
         seen_fall = 1'b1;
         if (hi_run < hi_min) hi_min = hi_run;
         if (hi_run > hi_max) hi_max = hi_run;
      end
      if (uart_en) hi_run++; else low_run++;
      if (pkt_done) pulses++;
      en_prev = uart_en;
      drive();
   endtask

   task automatic do_reset(input int n);
      sys_rst = 1'b1;
      a_en = 1'b0;
      b_en = 1'b0;
      drive();
      repeat (n) tick();
      sys_rst = 1'b0;
      cyc = 0;
      clear_stats();
   endtask

   logic [7:0] col_dat [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   int         col_cyc [8] = '{106, 210, 314, 420, 524, 628, 734, 838};
   logic       col_own [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      int bad;
      int guard;
      logic [9:0] frame;

      // Reset and INIT quiet period, then a single-byte packet from A.
      sys_rst = 1'b1;
      a_en = 1'b0;
      b_en = 1'b0;
      clear_stats();
      drive();
      do_reset(3);
      chk("rst_en", 32'(uart_en), 0);
      chk("rst_din", 32'(uart_din), 0);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_done", 32'(pkt_done), 0);
      chk("rst_aready", 32'(ifc.a_ready), 0);
      chk("rst_bready", 32'(ifc.b_ready), 0);

      a_q.push_back(9'h1A5);
      a_en = 1'b1;
      drive();
      bad = 0;
      repeat (104) begin
         tick();
         if (ifc.a_ready || uart_en) bad++;
      end
      chk("init_quiet", 32'(bad), 0);
      chk("idle_busy", 32'(busy), 0);
      tick();
      chk("load_aready", 32'(ifc.a_ready), 1);
      chk("load_bready", 32'(ifc.b_ready), 0);
      tick();
      chk("single_xfer_cyc", lg_cyc(0), 106);
      chk("single_din", 32'(uart_din), 32'h A5);
      chk("single_en", 32'(uart_en), 1);
      frame = {1'b1, uart_din, 1'b0};
      chk("single_frame", 32'(frame), 32'(10'b1101001010));
      repeat (103) tick();
      chk("single_predone", 32'(pulses), 0);
      chk("single_busy_wait", 32'(busy), 1);
      tick();
      chk("single_done", 32'(pkt_done), 1);
      chk("single_idle", 32'(busy), 0);
      chk("single_rises", 32'(rises), 1);
      chk("single_strobe_len", 32'(hi_min), 4);
      tick();
      chk("single_done_pulse", 32'(pkt_done), 0);

      // Collision after reset, followed by a second A packet to exercise rotation.
      do_reset(3);
      a_q = '{9'h011, 9'h022, 9'h133, 9'h077, 9'h188};
      b_q = '{9'h044, 9'h055, 9'h166};
      a_en = 1'b1;
      b_en = 1'b1;
      drive();
      repeat (950) tick();
      chk("col_count", 32'(log_dat.size()), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("col_dat%0d", i), lg_dat(i), 32'(col_dat[i]));
         chk($sformatf("col_cyc%0d", i), lg_cyc(i), 32'(col_cyc[i]));
         chk($sformatf("col_own%0d", i), lg_own(i), 32'(col_own[i]));
      end
      chk("col_pulses", 32'(pulses), 3);
      chk("col_rises", 32'(rises), 8);
      chk("col_min_gap", 32'(min_gap), 100);
      chk("col_hi_min", 32'(hi_min), 4);
      chk("col_hi_max", 32'(hi_max), 4);
      chk("col_both_ready", 32'(both_rdy), 0);

      // A stalls mid-packet while B waits: lock must hold.
      do_reset(3);
      a_q = '{9'h0C1, 9'h1C2};
      b_q = '{9'h1D1};
      a_en = 1'b1;
      b_en = 1'b1;
      drive();
      guard = 0;
      while (log_dat.size() < 1 && guard < 300) begin
         tick();
         guard++;
      end
      chk("hold_first_cyc", lg_cyc(0), 106);
      a_en = 1'b0;
      drive();
      while (cyc < 256) tick();
      chk("hold_busy", 32'(busy), 1);
      chk("hold_bready", 32'(ifc.b_ready), 0);
      chk("hold_en", 32'(uart_en), 0);
      chk("hold_owner", 32'(owner), 0);
      while (cyc < 406) tick();
      chk("hold_rises", 32'(rises), 1);
      chk("hold_count", 32'(log_dat.size()), 1);
      a_en = 1'b1;
      drive();
      while (cyc < 515) tick();
      chk("hold_b2_cyc", lg_cyc(1), 408);
      chk("hold_b2_dat", lg_dat(1), 32'h C2);
      chk("hold_b_cyc", lg_cyc(2), 514);
      chk("hold_b_dat", lg_dat(2), 32'h D1);
      chk("hold_b_own", lg_own(2), 1);
      chk("mid_en_before", 32'(uart_en), 1);

      // Reset during the second strobe cycle of B's byte.
      sys_rst = 1'b1;
      tick();
      chk("mid_en", 32'(uart_en), 0);
      chk("mid_owner", 32'(owner), 0);
      chk("mid_busy", 32'(busy), 1);
      chk("mid_din", 32'(uart_din), 0);
      chk("mid_done", 32'(pkt_done), 0);
      sys_rst = 1'b0;
      cyc = 0;
      clear_stats();
      a_q = '{9'h1F1};
      b_q = '{9'h1F2};
      drive();
      while (cyc < 100) tick();
      chk("mid_init_done", 32'(pulses), 0);
      chk("mid_init_rises", 32'(rises), 0);
      while (cyc < 220) tick();
      chk("mid_count", 32'(log_dat.size()), 2);
      chk("mid_a_cyc", lg_cyc(0), 106);
      chk("mid_a_own", lg_own(0), 0);
      chk("mid_b_cyc", lg_cyc(1), 212);
      chk("mid_b_own", lg_own(1), 1);
      chk("mid_pulses", 32'(pulses), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
